// File: rtl/if_fetch_unit_pkg.sv
// Shared fetch definitions: word geometry, reset defaults and PC helpers.
`ifndef IF_DEFS_SV
`define IF_DEFS_SV
package if_defs;

  localparam int          WORD_W              = 32;
  localparam int          INSTR_BYTES         = 4;
  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int          IM_SIZE_DEFAULT     = 1024;
  localparam int          QUEUE_DEPTH_DEFAULT = 2;

  // Byte address -> instruction memory word index.
  function automatic logic [WORD_W-1:0] word_index(input logic [WORD_W-1:0] pc);
    return {2'b00, pc[WORD_W-1:2]};
  endfunction

  // Force a byte address onto a word boundary.
  function automatic logic [WORD_W-1:0] align_pc(input logic [WORD_W-1:0] pc);
    return {pc[WORD_W-1:2], 2'b00};
  endfunction

endpackage
`endif

// File: rtl/if_fetch_unit_queue.sv
// 2-entry circular prefetch buffer holding {pc, instruction}.
// When empty, head keeps showing the last entry presented, so decode-side
// outputs hold their previous values (zero after reset).
module if_queue
  import if_defs::*;
#(
  parameter int DEPTH = QUEUE_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [63:0] push_data,
  output logic [63:0] head,
  output logic        full,
  output logic        empty,
  output logic [1:0]  count
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  logic [1:0][63:0] mem;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [63:0]      held;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == 2'd0);
  assign full    = (count == DEPTH_C);
  assign do_pop  = pop & ~empty;
  // A full queue can still accept when the head leaves in the same cycle;
  // the write lands in the slot being vacated, which becomes the new tail.
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? held : mem[rd_ptr];

  // Pointer / occupancy update; flush discards everything.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; payload needs no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end

  // Remember the last presented head so outputs hold across empty periods.
  always_ff @(posedge clock) begin
    if (reset)       held <= '0;
    else if (!empty) held <= mem[rd_ptr];
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, reads one word per cycle from a
// combinational instruction memory into a 2-entry prefetch queue, and
// presents {instruction, pc} to decode over valid/ready. Redirects flush.
module if_fetch_unit
  import if_defs::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          IM_SIZE     = IM_SIZE_DEFAULT,
  parameter int          QUEUE_DEPTH = QUEUE_DEPTH_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] im_address,
  input  logic [31:0] im_instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        done
);

  localparam logic [31:0] IM_SIZE_W = 32'(IM_SIZE);

  logic [WORD_W-1:0] pc;
  logic              in_range;
  logic              pop;
  logic              fetch_ok;
  logic [63:0]       q_head;
  logic              q_full;
  logic              q_empty;
  logic [1:0]        q_count;
  logic              unused_bits;

  assign im_address = word_index(pc);
  assign in_range   = (im_address < IM_SIZE_W);
  assign pop        = out_valid & out_ready;
  // Redirect wins over fetch; a full queue only accepts alongside a pop.
  assign fetch_ok   = ~done & ~redirect_valid & in_range & (~q_full | pop);

  assign out_valid       = ~q_empty;
  assign out_pc          = q_head[63:32];
  assign out_instruction = q_head[31:0];
  assign out_pc_plus4    = out_pc + 32'(INSTR_BYTES);

  assign unused_bits = ^{redirect_pc[1:0], q_count};

  // PC and end-of-memory flag; reset beats redirect beats fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc   <= align_pc(RESET_PC);
      done <= 1'b0;
    end else if (redirect_valid) begin
      pc   <= align_pc(redirect_pc);
      done <= 1'b0;
    end else begin
      if (fetch_ok) pc <= pc + 32'(INSTR_BYTES);
      if (!in_range) done <= 1'b1;
    end
  end

  if_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (fetch_ok),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data ({pc, im_instruction}),
    .head      (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

endmodule
